// File: rtl/dmem_access_unit_if.sv
// Request, data-memory and response channels of the memory-stage access unit.
// slave is the unit's own view; master is the view of EX, the memory and the load decoder.
interface dmem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;

    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_raw_data;
    logic [31:0] rsp_addr;
    logic        rsp_lb;
    logic        rsp_lbu;
    logic        rsp_lh;
    logic        rsp_lhu;
    logic        rsp_lw;
    logic        rsp_misaligned;
    logic        rsp_timeout;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_is_store, req_size, req_unsigned,
        input  mem_rdata, mem_rvalid, rsp_ready,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output rsp_valid, rsp_raw_data, rsp_addr,
        output rsp_lb, rsp_lbu, rsp_lh, rsp_lhu, rsp_lw, rsp_misaligned, rsp_timeout
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_is_store, req_size, req_unsigned,
        output mem_rdata, mem_rvalid, rsp_ready,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  rsp_valid, rsp_raw_data, rsp_addr,
        input  rsp_lb, rsp_lbu, rsp_lh, rsp_lhu, rsp_lw, rsp_misaligned, rsp_timeout
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage sequencer: one word-aligned data-memory access per load/store,
// returning a lane-shifted word and load-type strobes, with misalignment and timeout detection.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    dmem_access_unit_if.slave bus
);

    localparam logic [1:0]  SIZE_BYTE  = 2'b00;
    localparam logic [1:0]  SIZE_HALF  = 2'b01;
    localparam logic [1:0]  SIZE_WORD  = 2'b10;
    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        is_store;
        logic [1:0]  size;
        logic        is_unsigned;
    } req_t;

    state_t      state;
    req_t        req;
    logic [15:0] wait_count;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = lsb[0];
            SIZE_WORD: misaligned = (lsb != 2'b00);
            default:   misaligned = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SIZE_BYTE: byte_enables = 4'b0001 << lsb;
            SIZE_HALF: byte_enables = 4'b0011 << lsb;
            default:   byte_enables = 4'b1111;
        endcase
    endfunction

    // Replicating the store data into every lane lets the byte enables alone pick the target bytes.
    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_BYTE: lane_data = {4{wdata[7:0]}};
            SIZE_HALF: lane_data = {2{wdata[15:0]}};
            default:   lane_data = wdata;
        endcase
    endfunction

    // Strobe order is {lb, lbu, lh, lhu, lw}; word loads ignore the unsigned flag.
    function automatic logic [4:0] load_strobes(input logic [1:0] size, input logic is_unsigned);
        case (size)
            SIZE_BYTE: load_strobes = is_unsigned ? 5'b01000 : 5'b10000;
            SIZE_HALF: load_strobes = is_unsigned ? 5'b00010 : 5'b00100;
            default:   load_strobes = 5'b00001;
        endcase
    endfunction

    // NOTE: every register here is updated with <= so all reads in a cycle see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            req                <= '0;
            wait_count         <= '0;
            bus.req_ready      <= 1'b1;
            bus.mem_en         <= 1'b0;
            bus.mem_we         <= '0;
            bus.mem_addr       <= '0;
            bus.mem_wdata      <= '0;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_raw_data   <= '0;
            bus.rsp_addr       <= '0;
            {bus.rsp_lb, bus.rsp_lbu, bus.rsp_lh, bus.rsp_lhu, bus.rsp_lw} <= '0;
            bus.rsp_misaligned <= 1'b0;
            bus.rsp_timeout    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        req <= '{addr:        bus.req_addr,
                                 is_store:    bus.req_is_store,
                                 size:        bus.req_size,
                                 is_unsigned: bus.req_unsigned};
                        bus.req_ready <= 1'b0;
                        if (misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            state              <= RESP;
                            bus.rsp_valid      <= 1'b1;
                            bus.rsp_addr       <= bus.req_addr;
                            bus.rsp_raw_data   <= '0;
                            {bus.rsp_lb, bus.rsp_lbu, bus.rsp_lh, bus.rsp_lhu, bus.rsp_lw} <= '0;
                            bus.rsp_misaligned <= 1'b1;
                            bus.rsp_timeout    <= 1'b0;
                        end else begin
                            state         <= ISSUE;
                            bus.mem_en    <= 1'b1;
                            bus.mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            bus.mem_we    <= bus.req_is_store
                                             ? byte_enables(bus.req_size, bus.req_addr[1:0])
                                             : 4'b0000;
                            bus.mem_wdata <= lane_data(bus.req_size, bus.req_wdata);
                        end
                    end
                end

                ISSUE: begin
                    bus.mem_en <= 1'b0;
                    wait_count <= '0;
                    state      <= WAIT;
                end

                WAIT: begin
                    // An acknowledge on the expiry cycle still completes the access normally.
                    if (bus.mem_rvalid) begin
                        state              <= RESP;
                        bus.rsp_valid      <= 1'b1;
                        bus.rsp_addr       <= req.addr;
                        bus.rsp_misaligned <= 1'b0;
                        bus.rsp_timeout    <= 1'b0;
                        if (req.is_store) begin
                            bus.rsp_raw_data <= '0;
                            {bus.rsp_lb, bus.rsp_lbu, bus.rsp_lh, bus.rsp_lhu, bus.rsp_lw} <= '0;
                        end else begin
                            bus.rsp_raw_data <= bus.mem_rdata >> {req.addr[1:0], 3'b000};
                            {bus.rsp_lb, bus.rsp_lbu, bus.rsp_lh, bus.rsp_lhu, bus.rsp_lw} <=
                                load_strobes(req.size, req.is_unsigned);
                        end
                    end else if (wait_count == LAST_COUNT) begin
                        state              <= RESP;
                        bus.rsp_valid      <= 1'b1;
                        bus.rsp_addr       <= req.addr;
                        bus.rsp_raw_data   <= '0;
                        {bus.rsp_lb, bus.rsp_lbu, bus.rsp_lh, bus.rsp_lhu, bus.rsp_lw} <= '0;
                        bus.rsp_misaligned <= 1'b0;
                        bus.rsp_timeout    <= 1'b1;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: a transaction-level model predicts every output each
// cycle, and hand-computed literals pin latency, returned data and the issued memory access.
module tb_dmem_access_unit;

    localparam int TIMEOUT = 4;
    localparam int NEVER   = 1000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        is_store;
        logic [1:0]  size;
        logic        uns;
        int          delay;
        int          stall;
        logic [31:0] hand_raw;
        int          hand_lat;
    } txn_t;

    typedef struct {
        logic        store;
        logic        mis;
        logic        timeout;
        int          lat;
        logic [31:0] mem_addr;
        logic [3:0]  mem_we;
        logic [31:0] mem_wdata;
        logic [31:0] raw;
        logic [4:0]  strobes;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    dmem_access_unit_if bus ();

    dmem_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic        chk_en   = 1'b0;
    int          cyc_k    = 0;
    exp_t        cur;
    int          seen_lat;
    logic [31:0] seen_raw;
    logic [31:0] seen_maddr;
    logic [3:0]  seen_we;
    logic [31:0] seen_wdata;
    int          en_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Transaction-level expectation: what one request must produce, from size/offset rules.
    function automatic exp_t model(input txn_t t);
        exp_t e;
        int   lsb    = int'(t.addr[1:0]);
        int   nbytes = (t.size == 2'b11) ? 0 : (1 << t.size);
        e.store     = t.is_store;
        e.mis       = (nbytes == 0) ? 1'b1 : ((lsb % nbytes) != 0);
        e.timeout   = !e.mis && (t.delay >= TIMEOUT);
        e.lat       = e.mis ? 1 : (e.timeout ? TIMEOUT + 2 : 3 + t.delay);
        e.mem_addr  = t.addr & 32'hFFFF_FFFC;
        e.mem_we    = '0;
        e.mem_wdata = '0;
        if (!e.mis) begin
            for (int b = 0; b < 4; b++) begin
                if (t.is_store && b >= lsb && b < lsb + nbytes) e.mem_we[b] = 1'b1;
                e.mem_wdata[8*b +: 8] = t.wdata[8*(b % nbytes) +: 8];
            end
        end
        e.raw     = '0;
        e.strobes = '0;
        if (!e.mis && !e.timeout && !t.is_store) begin
            e.raw     = t.rdata >> (8 * lsb);
            e.strobes = 5'b10000 >> ((t.size == 2'b10) ? 4 : 2 * int'(t.size) + int'(t.uns));
        end
        return e;
    endfunction

    function automatic txn_t mk(input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic is_store,
                                input logic [1:0] size, input logic uns, input int delay,
                                input int stall, input logic [31:0] hand_raw, input int hand_lat);
        txn_t t;
        t.addr = addr;   t.wdata = wdata; t.rdata = rdata; t.is_store = is_store;
        t.size = size;   t.uns = uns;     t.delay = delay; t.stall = stall;
        t.hand_raw = hand_raw; t.hand_lat = hand_lat;
        return t;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check_bit("req_ready", bus.req_ready, cyc_k == 0);
            check_bit("mem_en", bus.mem_en, !cur.mis && cyc_k == 1);
            check_bit("rsp_valid", bus.rsp_valid, cyc_k >= cur.lat);
            if (!cur.mis && cyc_k >= 1 && cyc_k < cur.lat) begin
                check("mem_addr", bus.mem_addr, cur.mem_addr);
                check("mem_we", {28'b0, bus.mem_we}, {28'b0, cur.mem_we});
                if (cur.store) check("mem_wdata", bus.mem_wdata, cur.mem_wdata);
            end
            if (cyc_k >= cur.lat) begin
                check("rsp_raw_data", bus.rsp_raw_data, cur.raw);
                check("rsp_strobes",
                      {27'b0, bus.rsp_lb, bus.rsp_lbu, bus.rsp_lh, bus.rsp_lhu, bus.rsp_lw},
                      {27'b0, cur.strobes});
                check_bit("rsp_misaligned", bus.rsp_misaligned, cur.mis);
                check_bit("rsp_timeout", bus.rsp_timeout, cur.timeout);
            end
            if (bus.mem_en) en_count++;
            if (cyc_k == 1) begin
                seen_maddr = bus.mem_addr;
                seen_we    = bus.mem_we;
                seen_wdata = bus.mem_wdata;
            end
            if (bus.rsp_valid && seen_lat < 0) begin
                seen_lat = cyc_k;
                seen_raw = bus.rsp_raw_data;
            end
        end
    end

    task automatic run_txn(input txn_t t, input logic [31:0] req_addr_chk);
        int   k;
        logic done;
        cur              = model(t);
        seen_lat         = -1;
        seen_raw         = '0;
        en_count         = 0;
        cyc_k            = 0;
        bus.req_addr     = t.addr;
        bus.req_wdata    = t.wdata;
        bus.req_is_store = t.is_store;
        bus.req_size     = t.size;
        bus.req_unsigned = t.uns;
        bus.req_valid    = 1'b1;
        chk_en           = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hDEAD_0000;
        done = 1'b0;
        k    = 1;
        while (!done && k < 40) begin
            cyc_k          = k;
            bus.mem_rdata  = t.rdata;
            bus.mem_rvalid = !cur.mis && (k == 2 + t.delay);
            bus.rsp_ready  = (k >= cur.lat + t.stall);
            if (k == cur.lat) check("rsp_addr", bus.rsp_addr, req_addr_chk);
            @(posedge clk); #1;
            done = bus.rsp_ready && (k >= cur.lat);
            k++;
        end
        bus.mem_rvalid = 1'b0;
        bus.rsp_ready  = 1'b0;
        if (!done) check_bit("handshake_bound", 1'b0, 1'b1);
        check("latency", seen_lat, t.hand_lat);
        check("raw_literal", seen_raw, t.hand_raw);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_bit({tag, "_req_ready"}, bus.req_ready, 1'b1);
        check_bit({tag, "_mem_en"}, bus.mem_en, 1'b0);
        check({tag, "_mem_we"}, {28'b0, bus.mem_we}, 32'h0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        check_bit({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check({tag, "_rsp_raw"}, bus.rsp_raw_data, 32'h0);
        check({tag, "_rsp_addr"}, bus.rsp_addr, 32'h0);
        check({tag, "_rsp_flags"},
              {25'b0, bus.rsp_lb, bus.rsp_lbu, bus.rsp_lh, bus.rsp_lhu, bus.rsp_lw,
               bus.rsp_misaligned, bus.rsp_timeout}, 32'h0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        bus.req_is_store = 1'b0;
        bus.req_size     = '0;
        bus.req_unsigned = 1'b0;
        bus.mem_rdata    = '0;
        bus.mem_rvalid   = 1'b0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_idle_outputs("reset");

        // lb with sign bit set in the top lane
        run_txn(mk(32'h0000_1003, 32'h0, 32'h80AA_BBCC, 1'b0, 2'b00, 1'b0, 0, 0,
                   32'h0000_0080, 3), 32'h0000_1003);
        check("lb_mem_addr", seen_maddr, 32'h0000_1000);
        check("lb_mem_we", {28'b0, seen_we}, 32'h0);
        check("lb_mem_en_pulses", en_count, 1);
        // sh to the upper half
        run_txn(mk(32'h0000_2002, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b1, 2'b01, 1'b0, 0, 0,
                   32'h0, 3), 32'h0000_2002);
        check("sh_mem_we", {28'b0, seen_we}, 32'h0000_000C);
        check("sh_mem_wdata", seen_wdata, 32'hABCD_ABCD);
        // misaligned: lw, lhu at odd address, illegal size
        run_txn(mk(32'h0000_3001, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 0, 0, 32'h0, 1), 32'h0000_3001);
        check("mis_mem_en_pulses", en_count, 0);
        run_txn(mk(32'h0000_3001, 32'h0, 32'h0, 1'b0, 2'b01, 1'b1, 0, 0, 32'h0, 1), 32'h0000_3001);
        run_txn(mk(32'h0000_3000, 32'h0, 32'h0, 1'b0, 2'b11, 1'b0, 0, 0, 32'h0, 1), 32'h0000_3000);
        // timeout, then acknowledge exactly on the expiry cycle
        run_txn(mk(32'h0000_5000, 32'h0, 32'h1111_1111, 1'b0, 2'b10, 1'b0, NEVER, 0,
                   32'h0, 6), 32'h0000_5000);
        run_txn(mk(32'h0000_5004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2'b10, 1'b0, TIMEOUT - 1, 0,
                   32'hDEAD_BEEF, 6), 32'h0000_5004);
        // lhu with back-pressure on the response
        run_txn(mk(32'h0000_4002, 32'h0, 32'hF00D_1234, 1'b0, 2'b01, 1'b1, 0, 5,
                   32'h0000_F00D, 3), 32'h0000_4002);
        run_txn(mk(32'h0000_6001, 32'h0, 32'h1122_3344, 1'b0, 2'b00, 1'b1, 1, 0,
                   32'h0011_2233, 4), 32'h0000_6001);
        run_txn(mk(32'h0000_6000, 32'h0, 32'h0000_8001, 1'b0, 2'b01, 1'b0, 0, 1,
                   32'h0000_8001, 3), 32'h0000_6000);
        run_txn(mk(32'h0000_7003, 32'h0000_00A5, 32'h0, 1'b1, 2'b00, 1'b0, 0, 0,
                   32'h0, 3), 32'h0000_7003);
        check("sb_mem_we", {28'b0, seen_we}, 32'h0000_0008);
        check("sb_mem_wdata", seen_wdata, 32'hA5A5_A5A5);
        run_txn(mk(32'h0000_7000, 32'hCAFE_F00D, 32'h0, 1'b1, 2'b10, 1'b0, 2, 0,
                   32'h0, 5), 32'h0000_7000);
        run_txn(mk(32'h0000_8000, 32'h0, 32'h0102_0304, 1'b0, 2'b10, 1'b1, 0, 0,
                   32'h0102_0304, 3), 32'h0000_8000);
        run_txn(mk(32'h0000_7003, 32'h0000_005A, 32'h0, 1'b1, 2'b00, 1'b0, NEVER, 2,
                   32'h0, 6), 32'h0000_7003);

        // Reset in WAIT, then a stray acknowledge while idle
        chk_en           = 1'b0;
        bus.req_addr     = 32'h0000_9000;
        bus.req_is_store = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_valid    = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        bus.mem_rdata  = 32'h1234_5678;
        bus.mem_rvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        check_idle_outputs("stray_rvalid");
        @(posedge clk); #1;
        check_idle_outputs("stray_rvalid_2");
        run_txn(mk(32'h0000_9002, 32'h0, 32'h00AB_0000, 1'b0, 2'b00, 1'b0, 0, 0,
                   32'h0000_00AB, 3), 32'h0000_9002);
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Memory-stage sequencer for the RISC-V datapath; sits directly upstream of the load decoder.
- Accepts one load/store request per transaction from EX and issues a single word-aligned access to the data memory, generating byte enables and lane-replicated write data.
- Waits for the memory acknowledge and returns a lane-shifted raw word, the original address and one-hot load strobes (lb/lbu/lh/lhu/lw) for the decoder.
- Detects misaligned accesses and memory timeouts.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in WAIT before aborting with rsp_timeout (legal range 1..65535)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
req_addr  in  32  byte address
req_wdata  in  32  store data (LSBs significant)
req_is_store  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  zero-extend load (byte/half only)
mem_en  out  1  one-cycle access strobe
mem_we  out  4  byte write enables (0000 for loads)
mem_addr  out  32  {req_addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_rdata  in  32  read word
mem_rvalid  in  1  memory acknowledge (loads and stores)
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  consumer accepts response
rsp_raw_data  out  32  mem_rdata >> (8*addr[1:0]); 0 on store/error
rsp_addr  out  32  original req_addr
rsp_lb, rsp_lbu, rsp_lh, rsp_lhu, rsp_lw  out  1 each  one-hot load type; all 0 for store/error
rsp_misaligned  out  1  request rejected, no memory access
rsp_timeout  out  1  memory did not acknowledge

Behaviour:
- Reset: state IDLE; req_ready=1 the cycle after rst deasserts; mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, all rsp_* = 0, timeout counter = 0.
- Reset mid-transaction: abort to IDLE; a later mem_rvalid is ignored (mem_rvalid is sampled only in WAIT).
- The FSM has four states: IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - req_valid & req_ready latches every req_* field.
  - Misaligned request goes to RESP with rsp_misaligned=1 and no mem_en. Misaligned means size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_en=1 for exactly this cycle; mem_addr, mem_we and mem_wdata are valid.
  - Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. mem_we=0 for loads.
  - Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
  - Next state WAIT; the counter is cleared.
- WAIT:
  - mem_en=0. mem_addr, mem_we and mem_wdata stay held until RESP.
  - mem_rvalid=1 → RESP.
    - Load: register rsp_raw_data from the shifted mem_rdata and set exactly one strobe: size 00 gives lb (signed) or lbu (unsigned); 01 gives lh or lhu; 10 gives lw (req_unsigned ignored).
    - Store: raw=0, strobes 0.
  - No mem_rvalid: the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without mem_rvalid → RESP with rsp_timeout=1, raw=0, strobes 0.
  - mem_rvalid in the same cycle as expiry: mem_rvalid wins and there is no timeout.
- RESP:
  - rsp_valid=1; all rsp_* stable while rsp_valid & !rsp_ready.
  - rsp_valid & rsp_ready → IDLE with rsp_valid=0 the next cycle. The other rsp_* hold their values, and the consumer ignores them.
  - No new request is accepted in the handshake cycle.
- Latency, accept (cycle 0) to rsp_valid:
  - Load/store: 3 cycles with mem_rvalid at the earliest cycle (cycle 2).
  - Misaligned: 1 cycle.
  - Timeout: TIMEOUT_CYCLES+2 cycles.
- Throughput: at most one outstanding transaction; one transaction per 4 cycles at best.
- rsp_addr always equals the accepted req_addr, including on errors.

Test Plan:
- lb at addr 0x0000_1003, memory returns 0x80AA_BBCC next cycle → mem_addr=0x0000_1000, mem_we=0000, single mem_en pulse; rsp_raw_data=0x0000_0080, rsp_lb=1, rsp_valid at cycle 3.
- sh at 0x0000_2002, wdata 0x1234_ABCD → mem_we=1100, mem_wdata=0xABCD_ABCD; rsp_valid with all strobes 0, rsp_raw_data=0.
- lw at 0x0000_3001 → no mem_en; rsp_misaligned=1 one cycle after accept. Repeat with lhu at 0x...1 and req_size=11 → both misaligned.
- TIMEOUT_CYCLES=4, lw with mem_rvalid never asserted → rsp_timeout=1, rsp_valid at cycle 6. Separate run with mem_rvalid on the expiry cycle → normal response, rsp_timeout=0.
- lhu at 0x0000_4002, mem_rdata 0xF00D_1234, rsp_ready held low 5 cycles → rsp_raw_data=0x0000_F00D and rsp_lhu=1 stable throughout; req_ready=0 until the cycle after the handshake.
- rst asserted during WAIT, then mem_rvalid pulsed in IDLE → outputs all 0, no rsp_valid, next request handled normally.
